// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for the multi-cycle 16-bit MIPS datapath. It sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), drives the ALU control code and
// datapath mux selects, and keeps a registered copy of the ALU flags. It also
// runs the memory request/ready handshake and abandons an access with a
// one-cycle timeout pulse if memory does not answer in time.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : illegal opcode/funct is caught in DECODE, illegal_op pulses and
//               the FSM returns straight to FETCH (instruction skipped).
//   undefined : illegal_op is tied 0 and illegal encodings run as a NOP EXEC.
//
// Parameters
//   PC_INC        constant the datapath selects on alu_src_b=01
//   MEM_WAIT_MAX  cycles to wait on mem_ready before timing out (1..255)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   run                 permits a new fetch (looked at in FETCH only)
//   opcode, funct       instr[15:12], instr[2:0] from the instruction register
//   alu_zero/neg/carry  combinational ALU flags
//   mem_ready           memory completes the current access this cycle
//   alu_control         000 add, 001 sub, 010 and, 011 or
//   alu_src_a/b         ALU operand selects
//   pc_src, pc_write    PC source select and load
//   ir_write            instruction register load
//   mem_req/mem_we/iord memory request, write qualifier, address select
//   reg_write/reg_dst/mem_to_reg  register-file write controls
//   flags               registered {N,C,Z}
//   mem_timeout         one-cycle pulse when a handshake times out
//   illegal_op          illegal-instruction pulse (trap build only)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int unsigned PC_INC       = 2,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_carry,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [2:0] flags,
    output logic       mem_timeout,
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAddi  = 4'b0001;
    localparam logic [3:0] OpLw    = 4'b0010;
    localparam logic [3:0] OpSw    = 4'b0011;
    localparam logic [3:0] OpBeq   = 4'b0100;
    localparam logic [3:0] OpBlt   = 4'b0101;
    localparam logic [3:0] OpBcs   = 4'b0110;
    localparam logic [3:0] OpJ     = 4'b0111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBPcInc  = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh  = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);

    // Elaboration-time guard on the configuration range.
    if (PC_INC == 0 || MEM_WAIT_MAX < 1 || MEM_WAIT_MAX > 255) begin : g_param_check
        $error("mips_multicycle_ctrl: PC_INC must be nonzero, MEM_WAIT_MAX in 1..255");
    end

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] flags_q, flags_d;
    logic       illegal;
    logic       timeout;
    logic       br_taken;

    // Reserved funct codes (1xx) of R-type and the whole upper opcode half.
    assign illegal = opcode[3] || ((opcode == OpRtype) && funct[2]);
    assign timeout = (wait_cnt_q == WaitMax);

    always_comb begin
        unique case (opcode)
            OpBeq:   br_taken = alu_zero;
            OpBlt:   br_taken = alu_neg;
            OpBcs:   br_taken = alu_carry;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            flags_q    <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        // Counter clears unless a request is still waiting in this state.
        wait_cnt_d  = '0;
        flags_d     = flags_q;
        alu_control = AluAdd;
        alu_src_a   = 1'b0;
        alu_src_b   = SrcBReg;
        pc_src      = PcSrcAlu;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        mem_timeout = 1'b0;
        illegal_op  = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (run) begin
                    if (timeout) begin
                        // Abandon the fetch; stay in FETCH with no IR/PC update.
                        mem_timeout = 1'b1;
                    end else begin
                        mem_req   = 1'b1;
                        alu_src_b = SrcBPcInc;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                            state_d  = StDecode;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end
                end
            end

            StDecode: begin
                // Speculative branch target into ALUOut.
                alu_src_b = SrcBImmSh;
`ifdef ILLEGAL_TRAP_EN
                if (illegal) begin
                    illegal_op = 1'b1;
                    state_d    = StFetch;
                end else begin
                    state_d = StExec;
                end
`else
                state_d = StExec;
`endif
            end

            StExec: begin
                state_d = StFetch;
                if (!illegal) begin
                    case (opcode)
                        OpRtype: begin
                            alu_src_a   = 1'b1;
                            alu_control = funct;
                            flags_d     = {alu_neg, alu_carry, alu_zero};
                            state_d     = StWb;
                        end
                        OpAddi: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SrcBImm;
                            flags_d   = {alu_neg, alu_carry, alu_zero};
                            state_d   = StWb;
                        end
                        OpLw, OpSw: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SrcBImm;
                            state_d   = StMem;
                        end
                        OpBeq, OpBlt, OpBcs: begin
                            alu_src_a   = 1'b1;
                            alu_control = AluSub;
                            flags_d     = {alu_neg, alu_carry, alu_zero};
                            if (br_taken) begin
                                pc_write = 1'b1;
                                pc_src   = PcSrcAluOut;
                            end
                        end
                        OpJ: begin
                            pc_write = 1'b1;
                            pc_src   = PcSrcJump;
                        end
                        default: ;
                    endcase
                end
            end

            StMem: begin
                if (timeout) begin
                    // Drop the access; a load never reaches WB.
                    mem_timeout = 1'b1;
                    state_d     = StFetch;
                end else begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OpSw);
                    if (mem_ready) begin
                        state_d = (opcode == OpSw) ? StFetch : StWb;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OpRtype);
                mem_to_reg = (opcode == OpLw);
                state_d    = StFetch;
            end

            default: state_d = StFetch;
        endcase

        // Outputs follow rst_n asynchronously so a pending request drops at once.
        if (!rst_n) begin
            alu_control = AluAdd;
            alu_src_a   = 1'b0;
            alu_src_b   = SrcBReg;
            pc_src      = PcSrcAlu;
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            mem_timeout = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each task queues per-cycle
// stimulus together with the expected output vector, then replays the queue,
// comparing the DUT against the popped expectation on the falling edge.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       run;
        logic [3:0] op;
        logic [2:0] fn;
        logic       n;
        logic       c;
        logic       z;
        logic       rdy;
    } in_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mem_timeout;
        logic       illegal_op;
        logic [2:0] flags;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       alu_zero, alu_neg, alu_carry, mem_ready;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_write, ir_write, mem_req, mem_we, iord;
    logic       reg_write, reg_dst, mem_to_reg, mem_timeout, illegal_op;
    logic [2:0] flags;
    out_t       act;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] mflags = 3'b000;

    in_t        in_q[$];
    out_t       exp_q[$];
    string      nm_q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .PC_INC       (2),
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .alu_carry   (alu_carry),
        .mem_ready   (mem_ready),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .flags       (flags),
        .mem_timeout (mem_timeout),
        .illegal_op  (illegal_op)
    );

    assign act = {alu_control, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_req,
                  mem_we, iord, reg_write, reg_dst, mem_to_reg, mem_timeout, illegal_op, flags};

    // ---------------- stimulus / expectation builders ----------------
    function automatic in_t mk_in(logic r, logic [3:0] op, logic [2:0] fn,
                                  logic n, logic c, logic z, logic rdy);
        in_t i;
        i.run = r; i.op = op; i.fn = fn; i.n = n; i.c = c; i.z = z; i.rdy = rdy;
        return i;
    endfunction

    function automatic out_t o_idle();
        out_t o = '0;
        o.flags = mflags;
        return o;
    endfunction

    function automatic out_t o_fetch(logic rdy);
        out_t o = o_idle();
        o.mem_req   = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    function automatic out_t o_decode(logic ill);
        out_t o = o_idle();
        o.alu_src_b = 2'b11;
`ifdef ILLEGAL_TRAP_EN
        o.illegal_op = ill;
`else
        if (ill) o.illegal_op = 1'b0;
`endif
        return o;
    endfunction

    function automatic out_t o_exec_r(logic [2:0] fn);
        out_t o = o_idle();
        o.alu_src_a   = 1'b1;
        o.alu_control = fn;
        return o;
    endfunction

    function automatic out_t o_exec_imm();
        out_t o = o_idle();
        o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10;
        return o;
    endfunction

    function automatic out_t o_exec_br(logic taken);
        out_t o = o_idle();
        o.alu_src_a   = 1'b1;
        o.alu_control = 3'b001;
        o.pc_write    = taken;
        o.pc_src      = taken ? 2'b01 : 2'b00;
        return o;
    endfunction

    function automatic out_t o_exec_j();
        out_t o = o_idle();
        o.pc_write = 1'b1;
        o.pc_src   = 2'b10;
        return o;
    endfunction

    function automatic out_t o_mem(logic we);
        out_t o = o_idle();
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
        o.mem_we  = we;
        return o;
    endfunction

    function automatic out_t o_wb(logic dst, logic m2r);
        out_t o = o_idle();
        o.reg_write  = 1'b1;
        o.reg_dst    = dst;
        o.mem_to_reg = m2r;
        return o;
    endfunction

    function automatic out_t o_tmo();
        out_t o = o_idle();
        o.mem_timeout = 1'b1;
        return o;
    endfunction

    task automatic push(input in_t i, input out_t e, input string nm);
        in_q.push_back(i);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic drive(input in_t i);
        run = i.run; opcode = i.op; funct = i.fn;
        alu_neg = i.n; alu_carry = i.c; alu_zero = i.z; mem_ready = i.rdy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        out_t z = '0;
        drive(mk_in(1'b1, 4'b0010, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1));
        #2;
        checks++;
        if (act !== z) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", act, z);
        end
        @(posedge clk); #1;
        checks++;
        if (act !== z) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", act, z);
        end
        rst_n = 1'b1;
        push(mk_in(1, 4'b0000, 3'b000, 0, 0, 0, 0), o_fetch(1'b0), "reset_release_fetch");
        push(mk_in(0, 4'b0000, 3'b000, 0, 0, 0, 0), o_idle(), "reset_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_sub();
        in_t i = mk_in(1, 4'b0000, 3'b001, 0, 0, 1, 1);
        push(i, o_fetch(1'b1), "sub_fetch");
        push(i, o_decode(1'b0), "sub_decode");
        push(i, o_exec_r(3'b001), "sub_exec");
        mflags = 3'b001;
        push(i, o_wb(1'b1, 1'b0), "sub_wb");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "sub_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_lw();
        in_t  i = mk_in(1, 4'b0010, 3'b000, 1, 1, 1, 1);
        in_t  w = mk_in(1, 4'b0010, 3'b000, 1, 1, 1, 0);
        out_t z = '0;
        push(i, o_fetch(1'b1), "rlw_fetch");
        push(i, o_decode(1'b0), "rlw_decode");
        push(i, o_exec_imm(), "rlw_exec");
        push(w, o_mem(1'b0), "rlw_mem_wait0");
        push(w, o_mem(1'b0), "rlw_mem_wait1");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
        drive(w);
        rst_n = 1'b0;
        mflags = 3'b000;
        #2;
        checks++;
        if (act !== z) begin
            errors++;
            $display("FAIL reset_mid_lw: got %h want %h", act, z);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(mk_in(1, 4'b0010, 3'b000, 0, 0, 0, 0), o_fetch(1'b0), "rlw_release_fetch");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "rlw_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        in_t i = mk_in(1, 4'b0010, 3'b000, 1, 0, 1, 1);
        in_t w = mk_in(1, 4'b0010, 3'b000, 1, 0, 1, 0);
        push(i, o_fetch(1'b1), "lw_fetch");
        push(i, o_decode(1'b0), "lw_decode");
        push(i, o_exec_imm(), "lw_exec");
        for (int k = 0; k < 3; k++) push(w, o_mem(1'b0), "lw_mem_wait");
        push(i, o_mem(1'b0), "lw_mem_ready");
        push(i, o_wb(1'b0, 1'b1), "lw_wb");
        push(mk_in(1, 0, 0, 0, 0, 0, 0), o_fetch(1'b0), "lw_next_fetch");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "lw_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        in_t t = mk_in(1, 4'b0101, 3'b000, 1, 0, 0, 1);
        in_t n = mk_in(1, 4'b0101, 3'b000, 0, 0, 0, 1);
        push(t, o_fetch(1'b1), "blt_t_fetch");
        push(t, o_decode(1'b0), "blt_t_decode");
        push(t, o_exec_br(1'b1), "blt_t_exec");
        mflags = 3'b100;
        push(n, o_fetch(1'b1), "blt_n_fetch");
        push(n, o_decode(1'b0), "blt_n_decode");
        push(n, o_exec_br(1'b0), "blt_n_exec");
        mflags = 3'b000;
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "blt_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        in_t f = mk_in(1, 4'b0011, 3'b000, 1, 1, 1, 0);
        in_t s = mk_in(1, 4'b0011, 3'b000, 1, 1, 1, 1);
        for (int k = 0; k < 15; k++) push(f, o_fetch(1'b0), "tmo_fetch_wait");
        push(f, o_tmo(), "tmo_fetch_pulse");
        push(f, o_fetch(1'b0), "tmo_fetch_retry");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "tmo_idle0");
        // SW whose data phase never completes.
        push(s, o_fetch(1'b1), "tmo_sw_fetch");
        push(s, o_decode(1'b0), "tmo_sw_decode");
        push(s, o_exec_imm(), "tmo_sw_exec");
        for (int k = 0; k < 15; k++) push(f, o_mem(1'b1), "tmo_sw_mem_wait");
        push(f, o_tmo(), "tmo_mem_pulse");
        push(f, o_fetch(1'b0), "tmo_mem_back_fetch");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "tmo_idle1");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        in_t o = mk_in(1, 4'b1010, 3'b000, 1, 1, 1, 1);
        in_t r = mk_in(1, 4'b0000, 3'b110, 1, 1, 1, 1);
        push(o, o_fetch(1'b1), "ill_op_fetch");
        push(o, o_decode(1'b1), "ill_op_decode");
`ifndef ILLEGAL_TRAP_EN
        push(o, o_idle(), "ill_op_exec_nop");
`endif
        push(mk_in(1, 4'b1010, 0, 1, 1, 1, 0), o_fetch(1'b0), "ill_op_next_fetch");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "ill_op_idle");
        push(r, o_fetch(1'b1), "ill_fn_fetch");
        push(r, o_decode(1'b1), "ill_fn_decode");
`ifndef ILLEGAL_TRAP_EN
        push(r, o_idle(), "ill_fn_exec_nop");
`endif
        push(mk_in(1, 4'b0000, 3'b110, 1, 1, 1, 0), o_fetch(1'b0), "ill_fn_next_fetch");
        push(mk_in(0, 0, 0, 0, 0, 0, 0), o_idle(), "ill_fn_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        in_t ad = mk_in(1, 4'b0001, 3'b000, 0, 1, 0, 1);
        in_t sw = mk_in(1, 4'b0011, 3'b000, 1, 1, 1, 1);
        in_t jj = mk_in(1, 4'b0111, 3'b000, 1, 0, 1, 1);
        in_t bq = mk_in(1, 4'b0100, 3'b000, 0, 0, 1, 1);
        in_t bc = mk_in(1, 4'b0110, 3'b000, 0, 1, 0, 1);
        in_t bn = mk_in(1, 4'b0110, 3'b000, 1, 0, 0, 1);
        in_t ra = mk_in(1, 4'b0000, 3'b010, 0, 0, 1, 1);
        in_t ro = mk_in(1, 4'b0000, 3'b011, 1, 1, 0, 1);
        push(ad, o_fetch(1'b1), "addi_fetch");
        push(ad, o_decode(1'b0), "addi_decode");
        push(ad, o_exec_imm(), "addi_exec");
        mflags = 3'b010;
        push(ad, o_wb(1'b0, 1'b0), "addi_wb");
        push(sw, o_fetch(1'b1), "sw_fetch");
        push(sw, o_decode(1'b0), "sw_decode");
        push(sw, o_exec_imm(), "sw_exec");
        push(sw, o_mem(1'b1), "sw_mem");
        push(jj, o_fetch(1'b1), "j_fetch");
        push(jj, o_decode(1'b0), "j_decode");
        push(jj, o_exec_j(), "j_exec");
        push(bq, o_fetch(1'b1), "beq_fetch");
        push(bq, o_decode(1'b0), "beq_decode");
        push(bq, o_exec_br(1'b1), "beq_exec_taken");
        mflags = 3'b001;
        push(bc, o_fetch(1'b1), "bcs_fetch");
        push(bc, o_decode(1'b0), "bcs_decode");
        push(bc, o_exec_br(1'b1), "bcs_exec_taken");
        mflags = 3'b010;
        push(bn, o_fetch(1'b1), "bcs2_fetch");
        push(bn, o_decode(1'b0), "bcs2_decode");
        push(bn, o_exec_br(1'b0), "bcs2_exec_not_taken");
        mflags = 3'b100;
        push(ra, o_fetch(1'b1), "and_fetch");
        push(ra, o_decode(1'b0), "and_decode");
        push(ra, o_exec_r(3'b010), "and_exec");
        mflags = 3'b001;
        push(ra, o_wb(1'b1, 1'b0), "and_wb");
        push(ro, o_fetch(1'b1), "or_fetch");
        push(ro, o_decode(1'b0), "or_decode");
        push(ro, o_exec_r(3'b011), "or_exec");
        mflags = 3'b110;
        push(ro, o_wb(1'b1, 1'b0), "or_wb");
        push(mk_in(0, 0, 0, 0, 0, 0, 1), o_idle(), "b2b_idle");
        while (in_q.size() > 0) begin
            out_t e; string nm;
            drive(in_q.pop_front());
            @(negedge clk);
            e = exp_q.pop_front(); nm = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h want %h", nm, act, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype_sub();
        test_reset_mid_lw();
        test_lw_wait();
        test_branch();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle main control FSM for the 16-bit MIPS datapath. It drives the ALU with its 3-bit ALU control code and sequences fetch, decode, execute, memory and writeback. It consumes the ALU's Zero, Negative and Carry flags for branch resolution and keeps a registered copy of them. It sits between the instruction register and the datapath muxes, register-file and memory enables, and also runs the memory request/ready handshake.

Parameters:
PC_INC, 2, constant selected on alu_src_b=01 for PC increment (byte-addressed 16-bit words)
MEM_WAIT_MAX, 15, max cycles waiting on mem_ready before timeout (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  permits a new fetch; sampled in FETCH only
opcode  input  4  instr[15:12] from instruction register
funct  input  3  instr[2:0], R-type sub-op
alu_zero  input  1  ALU Zero flag (combinational, same cycle)
alu_neg  input  1  ALU Negative flag
alu_carry  input  1  ALU Carry flag
mem_ready  input  1  memory completes current access this cycle
alu_control  output  3  000 add, 001 sub, 010 and, 011 or
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00 reg B, 01 PC_INC, 10 sign-ext imm, 11 imm<<1
pc_src  output  2  00 ALU result, 01 ALUOut reg, 10 jump target
pc_write  output  1  load PC
ir_write  output  1  load instruction register
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  write qualifier for mem_req
iord  output  1  memory address: 0=PC, 1=ALUOut
reg_write  output  1  register-file write enable
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
flags  output  3  registered {N,C,Z}
mem_timeout  output  1  one-cycle pulse on handshake timeout
illegal_op  output  1  see Optional Feature

Behaviour:
- Reset (async, rst_n low): state=FETCH; all outputs 0; flags=000; wait counter=0. Takes effect mid-instruction; any pending mem_req drops immediately.
- Opcode map: 0000 R-type (funct 000 add, 001 sub, 010 and, 011 or; others illegal); 0001 ADDI; 0010 LW; 0011 SW; 0100 BEQ (Z); 0101 BLT (N); 0110 BCS (C); 0111 J. Opcodes 1000-1111 are illegal.
- FETCH: if run=0, idle with all outputs 0. If run=1: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=000. On mem_ready, pulse ir_write=1 and pc_write=1 (pc_src=00), then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=000 (branch target into ALUOut). Always go to EXEC.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_control per funct; go to WB.
  - ADDI: src_b=10, add; go to WB.
  - LW/SW: src_b=10, add; go to MEM.
  - Branches: src_a=1, src_b=00, sub. If the selected flag is 1, pc_write=1 and pc_src=01. Go to FETCH.
  - J: pc_write=1, pc_src=10; go to FETCH.
- Flag capture: flags register loads {alu_neg, alu_carry, alu_zero} at the end of EXEC for R-type, ADDI and branches only.
- MEM: mem_req=1, iord=1, mem_we=1 for SW. On mem_ready: SW goes to FETCH, LW goes to WB.
- WB: reg_write=1 for one cycle. R-type uses reg_dst=1, mem_to_reg=0. ADDI uses reg_dst=0, mem_to_reg=0. LW uses reg_dst=0, mem_to_reg=1. Go to FETCH.
- Latency with mem_ready tied high: R/ADDI 4 cycles, LW 5, SW 4, branch/J 3.
- Handshake: mem_req stays high and the address selection stays stable until mem_ready. The wait counter increments each waiting cycle and clears on any state change. If it reaches MEM_WAIT_MAX: mem_timeout pulses, mem_req drops, the state goes to FETCH, and no PC, IR or register write occurs.
- mem_ready arriving outside FETCH/MEM is ignored.
- run deasserted mid-instruction has no effect until the next FETCH.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or funct in DECODE pulses illegal_op for one cycle and goes directly to FETCH with no writes. The PC has already advanced, so the instruction is skipped.
- Undefined: illegal_op is tied 0. Illegal encodings execute as NOP through EXEC (alu_control=000, no flag capture) and then FETCH: 3 cycles, no writes.

Test Plan:
- Reset mid-LW MEM wait: rst_n low -> all outputs 0, flags=000; after release with run=1, mem_req=1 and iord=0 the next cycle.
- R-type sub (opcode 0000, funct 001), mem_ready=1, alu_zero=1 -> alu_control=001 in EXEC, reg_write=1 with reg_dst=1 in cycle 4, flags=001.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with iord=1, then WB with mem_to_reg=1, reg_write=1; 8 cycles total.
- BLT with alu_neg=1 -> pc_write=1 and pc_src=01 in EXEC. Same with alu_neg=0 -> pc_write=0; 3 cycles each.
- FETCH with mem_ready held low, MEM_WAIT_MAX=15 -> mem_timeout pulses after 15 cycles, ir_write never asserts, state returns to FETCH.
- Opcode 1010 -> with ILLEGAL_TRAP_EN, illegal_op=1 in DECODE and next fetch in cycle 3. Without it, illegal_op=0, no reg_write or pc_write in EXEC, next fetch in cycle 4.
